// File: rtl/r_file_if.sv
// Register-file access bundle: two gated read ports and one write-back port.
// Reads are combinational (0 cycles), writes land on the next rising edge, no backpressure.
interface r_file_if;
  logic [4:0]  src_rs1;
  logic [4:0]  src_rs2;
  logic        rs1_valid;
  logic        rs2_valid;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] rs1;
  logic [31:0] rs2;

  modport master (
    output src_rs1, src_rs2, rs1_valid, rs2_valid, rd, rd_data, rd_valid,
    input  rs1, rs2
  );

  modport slave (
    input  src_rs1, src_rs2, rs1_valid, rs2_valid, rd, rd_data, rd_valid,
    output rs1, rs2
  );
endinterface

// File: rtl/r_file.sv
// 32x32 integer register file, x0 hard-wired to zero; 0-cycle reads, 1-edge writes.
// Always accepts a write (no backpressure); reset clears every entry asynchronously.
module r_file (
  input  logic     clk,
  input  logic     reset,
  r_file_if.slave  bus
);

  logic [31:0] regs [32];

  // Entry 0 is never written, so it holds its reset value of zero forever.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (bus.rd_valid && (bus.rd != 5'd0)) begin
      regs[bus.rd] <= bus.rd_data;
    end
  end

  assign bus.rs1 = (bus.rs1_valid && (bus.src_rs1 != 5'd0)) ? regs[bus.src_rs1] : 32'h0;
  assign bus.rs2 = (bus.rs2_valid && (bus.src_rs2 != 5'd0)) ? regs[bus.src_rs2] : 32'h0;

endmodule

// File: tb/tb_r_file.sv
// Randomized and directed checks of r_file against an array model of the architectural registers.
`timescale 1ns/1ps
module tb_r_file;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] model [32];

  r_file_if bus ();

  r_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic vld);
    if (!vld || idx == 5'd0) return 32'h0;
    return model[idx];
  endfunction

  // Advance one rising edge and apply the architectural write rule to the model.
  task automatic tick();
    @(posedge clk);
    if (reset && bus.rd_valid && bus.rd != 5'd0) model[bus.rd] = bus.rd_data;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] exp1, exp2;
    reset = 1'b0;
    clear_model();
    bus.rd = 5'd9; bus.rd_data = 32'hA5A5A5A5; bus.rd_valid = 1'b1;
    bus.rs1_valid = 1'b1; bus.rs2_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      bus.src_rs1 = 5'(i); bus.src_rs2 = 5'(31 - i);
      #1;
      if (bus.rs1 !== 32'h0 || bus.rs2 !== 32'h0) begin
        $display("FAIL reset_hold idx=%0d rs1=%h rs2=%h expected 0", i, bus.rs1, bus.rs2);
        fails++;
      end
      tests++;
    end
    bus.rd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      bus.src_rs1 = 5'(i); bus.src_rs2 = 5'(i);
      #0.1;
      exp1 = ref_read(bus.src_rs1, 1'b1);
      exp2 = ref_read(bus.src_rs2, 1'b1);
      if (bus.rs1 !== exp1 || bus.rs2 !== exp2) begin
        $display("FAIL reset_release idx=%0d rs1=%h rs2=%h expected %h/%h", i, bus.rs1, bus.rs2, exp1, exp2);
        fails++;
      end
      tests++;
    end
  endtask

  task automatic test_signed_write();
    bus.rd = 5'd1; bus.rd_data = 32'hFFFFFFFD; bus.rd_valid = 1'b1;
    tick();
    bus.rd = 5'd2; bus.rd_data = 32'h00000003;
    tick();
    bus.src_rs1 = 5'd1; bus.src_rs2 = 5'd2; bus.rs1_valid = 1'b1; bus.rs2_valid = 1'b1;
    bus.rd = 5'd3; bus.rd_data = 32'h00000002;
    #1;
    if (bus.rs1 !== 32'hFFFFFFFD || bus.rs2 !== 32'h00000003) begin
      $display("FAIL signed_readback rs1=%h rs2=%h expected fffffffd/00000003", bus.rs1, bus.rs2);
      fails++;
    end
    tests++;
    tick();
    bus.rd_valid = 1'b0;
    bus.src_rs1 = 5'd3;
    #1;
    if (bus.rs1 !== 32'h00000002) begin
      $display("FAIL write_x3 rs1=%h expected 00000002", bus.rs1);
      fails++;
    end
    tests++;
  endtask

  task automatic test_x0();
    bus.rd = 5'd0; bus.rd_data = 32'hDEADBEEF; bus.rd_valid = 1'b1;
    tick();
    bus.rd_valid = 1'b0;
    bus.src_rs1 = 5'd0; bus.src_rs2 = 5'd0; bus.rs1_valid = 1'b1; bus.rs2_valid = 1'b1;
    #1;
    if (bus.rs1 !== 32'h0 || bus.rs2 !== 32'h0) begin
      $display("FAIL x0_protect rs1=%h rs2=%h expected 0", bus.rs1, bus.rs2);
      fails++;
    end
    tests++;
  endtask

  task automatic test_valid_gating();
    bus.rd = 5'd5; bus.rd_data = 32'h12345678; bus.rd_valid = 1'b0;
    tick();
    bus.src_rs1 = 5'd5; bus.rs1_valid = 1'b1;
    #1;
    if (bus.rs1 !== 32'h0) begin
      $display("FAIL write_gated rs1=%h expected 0", bus.rs1);
      fails++;
    end
    tests++;
    bus.src_rs1 = 5'd1; bus.rs1_valid = 1'b0;
    bus.src_rs2 = 5'd1; bus.rs2_valid = 1'b1;
    #1;
    if (bus.rs1 !== 32'h0 || bus.rs2 !== 32'hFFFFFFFD) begin
      $display("FAIL read_gated rs1=%h rs2=%h expected 0/fffffffd", bus.rs1, bus.rs2);
      fails++;
    end
    tests++;
    bus.src_rs2 = 5'd1; bus.rs2_valid = 1'b0; bus.rs1_valid = 1'b1;
    #1;
    if (bus.rs1 !== 32'hFFFFFFFD || bus.rs2 !== 32'h0) begin
      $display("FAIL read_gated2 rs1=%h rs2=%h expected fffffffd/0", bus.rs1, bus.rs2);
      fails++;
    end
    tests++;
  endtask

  task automatic test_same_cycle();
    bus.rd = 5'd4; bus.rd_data = 32'd7; bus.rd_valid = 1'b1;
    tick();
    bus.rd_data = 32'd9;
    bus.src_rs1 = 5'd4; bus.src_rs2 = 5'd4; bus.rs1_valid = 1'b1; bus.rs2_valid = 1'b1;
    #1;
    if (bus.rs1 !== 32'd7 || bus.rs2 !== 32'd7) begin
      $display("FAIL same_cycle_before rs1=%h rs2=%h expected 7", bus.rs1, bus.rs2);
      fails++;
    end
    tests++;
    tick();
    bus.rd_valid = 1'b0;
    if (bus.rs1 !== 32'd9 || bus.rs2 !== 32'd9) begin
      $display("FAIL same_cycle_after rs1=%h rs2=%h expected 9", bus.rs1, bus.rs2);
      fails++;
    end
    tests++;
  endtask

  task automatic test_random();
    logic [31:0] exp1, exp2;
    for (int n = 0; n < 400; n++) begin
      bus.rd        = 5'($urandom_range(0, 31));
      bus.rd_data   = $urandom;
      bus.rd_valid  = 1'($urandom_range(0, 3) != 0);
      bus.src_rs1   = 5'($urandom_range(0, 31));
      bus.src_rs2   = ($urandom_range(0, 3) == 0) ? bus.rd : 5'($urandom_range(0, 31));
      bus.rs1_valid = 1'($urandom_range(0, 4) != 0);
      bus.rs2_valid = 1'($urandom_range(0, 4) != 0);
      #1;
      exp1 = ref_read(bus.src_rs1, bus.rs1_valid);
      exp2 = ref_read(bus.src_rs2, bus.rs2_valid);
      if (bus.rs1 !== exp1 || bus.rs2 !== exp2) begin
        $display("FAIL random n=%0d rs1=%h rs2=%h expected %h/%h", n, bus.rs1, bus.rs2, exp1, exp2);
        fails++;
      end
      tests++;
      tick();
    end
    bus.rd_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) begin
      bus.rd = 5'(i); bus.rd_data = 32'(i); bus.rd_valid = 1'b1;
      tick();
    end
    bus.rd_valid = 1'b0;
    bus.src_rs1 = 5'd17; bus.src_rs2 = 5'd31; bus.rs1_valid = 1'b1; bus.rs2_valid = 1'b1;
    #0.5;
    if (bus.rs1 !== 32'd17 || bus.rs2 !== 32'd31) begin
      $display("FAIL fill_check rs1=%h rs2=%h expected 11/1f", bus.rs1, bus.rs2);
      fails++;
    end
    tests++;
    // Pulse reset between edges and read everything back before the next edge.
    reset = 1'b0;
    clear_model();
    #0.25;
    for (int i = 0; i < 16; i++) begin
      bus.src_rs1 = 5'(i); bus.src_rs2 = 5'(i + 16);
      #0.25;
      if (bus.rs1 !== 32'h0 || bus.rs2 !== 32'h0) begin
        $display("FAIL async_reset idx=%0d rs1=%h rs2=%h expected 0", i, bus.rs1, bus.rs2);
        fails++;
      end
      tests++;
    end
    bus.rd = 5'd7; bus.rd_data = 32'h55; bus.rd_valid = 1'b1;
    tick();
    bus.rd_valid = 1'b0;
    reset = 1'b1;
    bus.src_rs1 = 5'd7; bus.src_rs2 = 5'd7;
    #1;
    if (bus.rs1 !== 32'h0 || bus.rs2 !== 32'h0) begin
      $display("FAIL write_in_reset rs1=%h rs2=%h expected 0", bus.rs1, bus.rs2);
      fails++;
    end
    tests++;
    bus.rd = 5'd7; bus.rd_data = 32'h66; bus.rd_valid = 1'b1;
    tick();
    bus.rd_valid = 1'b0;
    if (bus.rs1 !== 32'h66) begin
      $display("FAIL first_write_after_release rs1=%h expected 66", bus.rs1);
      fails++;
    end
    tests++;
  endtask

  initial begin
    bus.src_rs1 = 5'd0; bus.src_rs2 = 5'd0;
    bus.rs1_valid = 1'b0; bus.rs2_valid = 1'b0;
    bus.rd = 5'd0; bus.rd_data = 32'h0; bus.rd_valid = 1'b0;
    reset = 1'b0;
    clear_model();
    test_reset();
    test_signed_write();
    test_x0();
    test_valid_gating();
    test_same_cycle();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
